avmm_copy_master: RTL
=====================

Name: avmm_copy_master

Overview:
- Avalon-MM initiator (master) that drives the system1 on-chip memory slave port.
- Copies a block of 32-bit words from a source word address to a destination word address in the same 51200-word memory.
- One outstanding read at a time; byte lanes always fully enabled.
- Sits between a control agent (CPU register file or test sequencer) and the interconnect feeding the memory's s1 port.

Parameters:
- ADDR_W, 16, word-address width; matches the memory slave address port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MEM_DEPTH, 51200, number of words in the target memory; address wrap point.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address; latched on an accepted start.
- dst_addr  in  ADDR_W  first destination word address; latched on an accepted start.
- word_count  in  ADDR_W  number of words to copy; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- words_done  out  ADDR_W  count of completed writes.
- avm_address  out  ADDR_W  master word address.
- avm_byteenable  out  DATA_W/8  constant all-ones.
- avm_chipselect  out  1  high whenever avm_read or avm_write is high.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data qualifier.
- avm_waitrequest  in  1  slave stall; the request is held while this is high.

Behaviour:
- Reset values: busy=0, done=0, words_done=0, avm_read=0, avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0, avm_byteenable=all-ones. The FSM enters IDLE.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
  - IDLE, start=1: latch src, dst and count; clear words_done. Go to FINISH if count==0, otherwise RD_REQ. busy=1 from the next cycle.
  - RD_REQ: avm_read=1, avm_address=src_ptr. When avm_waitrequest=0, the read is accepted; deassert read next cycle and go to RD_WAIT.
  - RD_WAIT: wait for avm_readdatavalid. On valid, capture avm_readdata into the write-data register and go to WR_REQ. If readdatavalid arrives in the same cycle the read is accepted (zero-latency fabric), capture it and go directly to WR_REQ.
  - WR_REQ: avm_write=1, avm_address=dst_ptr, avm_writedata=captured word. When avm_waitrequest=0:
    - increment words_done, src_ptr and dst_ptr;
    - go to FINISH if words_done+1==count, else RD_REQ.
  - FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
- Request hold rule: while avm_waitrequest=1, address, writedata, read and write stay stable. read and write are never high together.
- Address pointers wrap to 0 after MEM_DEPTH-1. Pointer arithmetic is ADDR_W-bit with an explicit compare against MEM_DEPTH-1.
- Throughput: with zero waitrequest and read latency 1, each word takes 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
- start while busy: ignored; latched parameters do not change.
- Overlapping regions: the block copies in ascending order with no overlap detection. The software contract is that ascending overlap is safe only when dst < src.
- Unexpected avm_readdatavalid outside RD_WAIT: ignored.
- Reset asserted mid-copy: abort immediately to reset values and produce no done pulse. The memory contents are whatever was written so far.

Optional Feature:
- Macro: AVMM_COPY_CHECKSUM_EN.
- When defined:
  - adds output checksum, DATA_W bits, reset 0;
  - checksum is cleared on an accepted start;
  - each accepted write adds the written word, modulo 2^DATA_W;
  - checksum is stable once done pulses.
- When undefined: no port and no adder; all other behaviour is identical.

Decomposition:
- Shared package avmm_copy_pkg holds:
  - the state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH);
  - the localparams ADDR_W_DEF=16, DATA_W_DEF=32, MEM_DEPTH_DEF=51200;
  - a wrap-increment function.
- One sub-module, avmm_addr_ptr: a loadable, incrementing, wrapping address counter, instantiated twice (src and dst).

Test Plan:
- Basic copy: preload words 0..3 with 0x11111111..0x44444444; start src=0, dst=100, count=4, no waitrequest, read latency 1 -> words 100..103 match. done pulses at cycle 13 after start; words_done=4.
- Zero length: count=0 -> done one cycle after FINISH entry; no avm_read or avm_write ever asserted.
- Waitrequest stall: random 0-3 cycle waitrequest on each request -> address, data and strobes stay stable during stalls; copy of 16 words is correct.
- Wrap-around: src=51198, dst=10, count=4 -> reads addresses 51198, 51199, 0, 1; writes 10..13.
- Start while busy, then reset mid-copy: second start at cycle 5 is ignored. Reset at word 2 of 8 -> outputs return to reset values, no done pulse, only words 0..1 written.
- Checksum (AVMM_COPY_CHECKSUM_EN): copy 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001.

Source files
------------

// File: rtl/avmm_copy_pkg.sv
// avmm_copy_pkg: shared state encoding, default sizes and the wrapping
// pointer increment used by the Avalon-MM block-copy master.
package avmm_copy_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 51200;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FINISH
  } copy_state_t;

  // Next word address, folding back to 0 after the last word of the memory.
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/avmm_addr_ptr.sv
// avmm_addr_ptr: loadable word-address counter that wraps at MEM_DEPTH-1.
// Load has priority over increment.
module avmm_addr_ptr import avmm_copy_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_ptr
);

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;

  assign w_ptr_next = ADDR_W'(wrap_inc(32'(r_ptr), 32'(MEM_DEPTH)));
  assign o_ptr      = r_ptr;

  // Pointer register: load on a new copy, step after each accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/avmm_copy_master.sv
// avmm_copy_master: Avalon-MM initiator copying a block of words from a
// source to a destination region of the same memory, one read in flight.
// Optional build macro AVMM_COPY_CHECKSUM_EN adds a running sum of the
// written words on the 'checksum' output.
module avmm_copy_master import avmm_copy_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W-1:0]   word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   words_done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest
`ifdef AVMM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  copy_state_t       r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_read;
  logic              r_write;
  logic              r_cs;
  logic [ADDR_W-1:0] r_words;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_start_acc;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [ADDR_W-1:0] w_words_inc;
  logic [ADDR_W-1:0] w_src_ptr;
  logic [ADDR_W-1:0] w_dst_ptr;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_rd_acc    = (r_state == RD_REQ) && !avm_waitrequest;
  assign w_wr_acc    = (r_state == WR_REQ) && !avm_waitrequest;
  assign w_words_inc = r_words + ADDR_W'(1);

  // The source pointer always holds the address of the next read, so it
  // steps as soon as a read is accepted; the destination steps per write.
  avmm_addr_ptr #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_src_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start_acc),
    .i_load_val (src_addr),
    .i_inc      (w_rd_acc),
    .o_ptr      (w_src_ptr)
  );

  avmm_addr_ptr #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_dst_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start_acc),
    .i_load_val (dst_addr),
    .i_inc      (w_wr_acc),
    .o_ptr      (w_dst_ptr)
  );

  // Copy sequencer with registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_cs    <= 1'b0;
      r_words <= '0;
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_count <= word_count;
            r_words <= '0;
            if (word_count == '0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= RD_REQ;
              r_busy  <= 1'b1;
              r_read  <= 1'b1;
              r_cs    <= 1'b1;
              r_addr  <= src_addr;
            end
          end
        end
        RD_REQ: begin
          if (!avm_waitrequest) begin
            r_read <= 1'b0;
            if (avm_readdatavalid) begin
              // Zero-latency fabric: data returned with the accept.
              r_wdata <= avm_readdata;
              r_state <= WR_REQ;
              r_write <= 1'b1;
              r_addr  <= w_dst_ptr;
            end else begin
              r_state <= RD_WAIT;
              r_cs    <= 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (avm_readdatavalid) begin
            r_wdata <= avm_readdata;
            r_state <= WR_REQ;
            r_write <= 1'b1;
            r_cs    <= 1'b1;
            r_addr  <= w_dst_ptr;
          end
        end
        WR_REQ: begin
          if (!avm_waitrequest) begin
            r_write <= 1'b0;
            r_words <= w_words_inc;
            if (w_words_inc == r_count) begin
              r_state <= FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_cs    <= 1'b0;
            end else begin
              r_state <= RD_REQ;
              r_read  <= 1'b1;
              r_addr  <= w_src_ptr;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef AVMM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running modulo-2^DATA_W sum of every word actually written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_start_acc) begin
      r_checksum <= '0;
    end else if (w_wr_acc) begin
      r_checksum <= r_checksum + r_wdata;
    end
  end

  assign checksum = r_checksum;
`endif

  assign busy           = r_busy;
  assign done           = r_done;
  assign words_done     = r_words;
  assign avm_address    = r_addr;
  assign avm_byteenable = '1;
  assign avm_chipselect = r_cs;
  assign avm_read       = r_read;
  assign avm_write      = r_write;
  assign avm_writedata  = r_wdata;

endmodule
